sr_flop_driver: RTL and testbench
=================================

// Module: sr_flop_driver
// PURPOSE
//  Command-side controller for a bank of NCH sync-reset SR flops: the initiator that drives s/r
//  into the flops and checks q/qbar readback. Accepts set/clear requests over a valid/ready
//  handshake and emits exactly one legal one-cycle S or R pulse. Never drives s=r=1.
//  Initialises the bank out of its X reset state, then confirms each write via readback.
// PARAMETERS
//  NCH      4   number of SR flop channels driven
//  TIMEOUT  3   max CHECK cycles waiting for readback match (>=1)
//  IDXW     2   request channel index width (>= $clog2(NCH))
// PORTS
//  clk        in   1     clock, all logic on posedge
//  reset      in   1     synchronous, active-high
//  req_valid  in   1     request present
//  req_ready  out  1     driver can accept (high only in IDLE)
//  req_chan   in   IDXW  target channel index
//  req_val    in   1     1 = set (pulse s), 0 = clear (pulse r)
//  s          out  NCH   set pulses to flop bank
//  r          out  NCH   reset pulses to flop bank
//  q          in   NCH   flop q readback
//  qbar       in   NCH   flop qbar readback
//  rsp_valid  out  1     one-cycle response strobe
//  rsp_err    out  1     qualified by rsp_valid: 1 = bad index or readback timeout
//  rsp_chan   out  IDXW  channel of this response
//  init_done  out  1     sticky: bank initialised to all-zero
//  init_err   out  1     sticky: init readback never matched
// BEHAVIOUR
//  Reset: s=0, r=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_chan=0, init_done=0, init_err=0.
//    Shadow-valid bits are cleared and state=INIT.
//  States: INIT -> INIT_CHK -> IDLE -> {PULSE -> CHECK | RESP} -> RESP -> IDLE.
//  INIT: r = all ones for exactly 1 cycle (first cycle with reset low), s = 0.
//  INIT_CHK: match = (q==0 && qbar==all ones), evaluated from its 1st cycle, up to TIMEOUT cycles.
//    On match: init_done=1, shadow = 0 with all entries valid, go to IDLE.
//    On timeout: init_err=1, init_done stays 0, go to IDLE. Requests still serviced.
//  IDLE: req_ready=1. Accept on req_valid && req_ready; latch chan and val.
//  Accepted request, decided at acceptance:
//    - req_chan >= NCH: go to RESP with err=1. No pulse.
//    - shadow valid and shadow[chan]==val: go to RESP with err=0. No pulse.
//    - otherwise: go to PULSE.
//  PULSE: 1 cycle. s[chan]=val, r[chan]=~val, all other bits 0.
//  CHECK: ok = (q[chan]==val && qbar[chan]==~val), up to TIMEOUT cycles.
//    First CHECK cycle sees the flop's post-pulse value.
//    On ok: shadow[chan]=val, entry valid, err=0.
//    On timeout: shadow[chan] marked invalid (forces a pulse next time), err=1.
//  RESP: rsp_valid=1 for exactly 1 cycle, carrying rsp_err and rsp_chan. Next state IDLE.
//  Latency, ideal flop: accept edge 0, PULSE 1, CHECK 2, RESP 3. Next accept in cycle 4.
//  Latency, no-op or bad index: RESP in cycle 1 after acceptance.
//  Invariant, every cycle: (s & r)==0 and $onehot0(s|r), except INIT where r is all ones.
//  s/r/rsp_valid are registered outputs.
//  req_ready is low in every state except IDLE. Requests are held off, never dropped.
//  Reset mid-operation (any state): next edge applies reset values. Any pulse stops.
//    No response is issued for the in-flight request. INIT reruns.
//  X on q/qbar counts as mismatch. Timeout counter is exactly ceil(log2(TIMEOUT+1)) bits.
//    Counter saturates and is cleared on each INIT_CHK/CHECK entry.
// STRUCTURE
//  Shared package sr_drv_pkg:
//    - state encoding localparams: ST_INIT, ST_INIT_CHK, ST_IDLE, ST_PULSE, ST_CHECK, ST_RESP
//    - response codes: RSP_OK, RSP_ERR
//  Sub-module sr_drv_timer: load/count/expire timeout counter, shared by INIT_CHK and CHECK.
//  Top level holds the FSM, the request latch, the shadow and valid registers, and the s/r decode.
// TESTING (bench instantiates NCH sr_flop_sync_reset_1 instances, clk period 2)
//  1 Reset 2 cycles, then release.
//    -> r=4'b1111 for 1 cycle, init_done=1 within 3 cycles. q=0, qbar=4'b1111.
//  2 Req chan=2, val=1.
//    -> s=4'b0100 for 1 cycle, rsp_valid 3 cycles after accept, rsp_err=0, q=4'b0100.
//  3 Repeat chan=2, val=1.
//    -> no s/r activity, rsp_valid in 1 cycle, err=0.
//  4 Req chan=5 with NCH=4.
//    -> no pulse, rsp_err=1, rsp_chan=5.
//  5 Force q[1] stuck at 0, req chan=1, val=1.
//    -> rsp_err=1 after TIMEOUT(3) CHECK cycles.
//    -> Next req chan=1, val=0 still pulses r=4'b0010.
//  6 Assert reset during PULSE.
//    -> s/r=0 next edge, no rsp_valid, INIT reruns.
//    -> Random 40-request soak: assertion (s&r)==0 never fires.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// Shared state encoding and response codes for the SR flop bank driver.
// Pure definitions: no logic, no latency, no flow control.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_INIT_CHK = 3'd1,
    ST_IDLE     = 3'd2,
    ST_PULSE    = 3'd3,
    ST_CHECK    = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/sr_drv_timer.sv
// Readback timeout counter: load clears, count advances (saturating), expire flags the last allowed cycle.
// Combinational expire from a registered count; no handshake.
module sr_drv_timer #(
  parameter int unsigned TIMEOUT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);

  localparam int unsigned   TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] SAT  = TW'(TIMEOUT);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_count && (r_cnt != SAT)) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  // Count equals the number of waiting cycles already spent, so LAST marks the final one.
  assign o_expire = (r_cnt >= LAST);

endmodule

// File: rtl/sr_flop_driver.sv
// Drives one-cycle S/R pulses into an NCH SR flop bank and confirms each write by q/qbar readback.
// Ideal write: response 3 cycles after accept; no-op/bad index: 1 cycle; req_ready only in IDLE.
module sr_flop_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned TIMEOUT = 3,
  parameter int unsigned IDXW    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [IDXW-1:0] req_chan,
  input  logic            req_val,
  output logic [NCH-1:0]  s,
  output logic [NCH-1:0]  r,
  input  logic [NCH-1:0]  q,
  input  logic [NCH-1:0]  qbar,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [IDXW-1:0] rsp_chan,
  output logic            init_done,
  output logic            init_err
);

  state_t          r_state, w_next;
  logic            r_init_fired;
  logic [IDXW-1:0] r_chan;
  logic            r_val;
  logic            r_err;
  logic [NCH-1:0]  r_shadow, r_svld;
  logic [NCH-1:0]  r_s, r_r, w_s_nxt, w_r_nxt;
  logic            r_rsp_vld, r_init_done, r_init_err;

  logic [NCH-1:0]  w_req_sel, w_sel;
  logic            w_req_bad, w_req_noop, w_chk_ok, w_init_ok;
  logic            w_expire, w_tmr_load, w_tmr_count;

  assign w_req_sel  = NCH'(1) << req_chan;
  assign w_sel      = NCH'(1) << r_chan;
  assign w_req_bad  = (32'(req_chan) >= NCH);
  assign w_req_noop = (|(r_svld & w_req_sel)) && ((|(r_shadow & w_req_sel)) == req_val);

  // X on readback makes these compares non-true, which is treated as a mismatch.
  assign w_chk_ok  = ((q & w_sel) == (r_val ? w_sel : '0)) &&
                     ((qbar & w_sel) == (r_val ? '0 : w_sel));
  assign w_init_ok = (q == '0) && (qbar == '1);

  assign w_tmr_load  = (w_next != r_state) && ((w_next == ST_INIT_CHK) || (w_next == ST_CHECK));
  assign w_tmr_count = (r_state == ST_INIT_CHK) || (r_state == ST_CHECK);

  sr_drv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_tmr_load),
    .i_count  (w_tmr_count),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_s_nxt = '0;
    w_r_nxt = '0;
    case (r_state)
      ST_INIT: begin
        if (r_init_fired) w_next = ST_INIT_CHK;
        else              w_r_nxt = '1;
      end
      ST_INIT_CHK: if (w_init_ok || w_expire) w_next = ST_IDLE;
      ST_IDLE: begin
        if (req_valid) begin
          if (w_req_bad || w_req_noop) begin
            w_next = ST_RESP;
          end else begin
            w_next  = ST_PULSE;
            w_s_nxt = req_val ? w_req_sel : '0;
            w_r_nxt = req_val ? '0 : w_req_sel;
          end
        end
      end
      ST_PULSE: w_next = ST_CHECK;
      ST_CHECK: if (w_chk_ok || w_expire) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_fired <= 1'b0;
      r_chan       <= '0;
      r_val        <= 1'b0;
      r_err        <= RSP_OK;
      r_shadow     <= '0;
      r_svld       <= '0;
      r_s          <= '0;
      r_r          <= '0;
      r_rsp_vld    <= 1'b0;
      r_init_done  <= 1'b0;
      r_init_err   <= 1'b0;
    end else begin
      r_init_fired <= (r_state == ST_INIT);
      r_s          <= w_s_nxt;
      r_r          <= w_r_nxt;
      r_rsp_vld    <= (w_next == ST_RESP);
      case (r_state)
        ST_INIT_CHK: begin
          if (w_init_ok) begin
            r_init_done <= 1'b1;
            r_shadow    <= '0;
            r_svld      <= '1;
          end else if (w_expire) begin
            r_init_err  <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            r_chan <= req_chan;
            r_val  <= req_val;
            r_err  <= w_req_bad ? RSP_ERR : RSP_OK;
          end
        end
        ST_CHECK: begin
          if (w_chk_ok) begin
            r_shadow <= r_val ? (r_shadow | w_sel) : (r_shadow & ~w_sel);
            r_svld   <= r_svld | w_sel;
            r_err    <= RSP_OK;
          end else if (w_expire) begin
            // Unknown flop contents: force a real pulse on the next write to this channel.
            r_svld   <= r_svld & ~w_sel;
            r_err    <= RSP_ERR;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign s         = r_s;
  assign r         = r_r;
  assign rsp_valid = r_rsp_vld;
  assign rsp_err   = r_err;
  assign rsp_chan  = r_chan;
  assign init_done = r_init_done;
  assign init_err  = r_init_err;

endmodule

// File: tb/tb_sr_flop_driver.sv
// Bench for sr_flop_driver: behavioural SR flop bank, request-level reference model, random soak.
module tb_sr_flop_driver;

  localparam int NCH     = 4;
  localparam int TIMEOUT = 3;
  localparam int IDXW    = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic [IDXW-1:0] req_chan = '0;
  logic            req_val = 1'b0;
  logic            req_ready;
  logic [NCH-1:0]  s, r, q, qbar;
  logic            rsp_valid, rsp_err;
  logic [IDXW-1:0] rsp_chan;
  logic            init_done, init_err;

  logic [NCH-1:0]  fq;
  logic [NCH-1:0]  stuck0 = '0;
  bit              mon_en = 1'b0;
  int              n_checks = 0;
  int              n_fail = 0;

  // Reference model: what the driver believes, and what the bank really holds.
  logic [NCH-1:0]  m_known, m_shadow, m_flop;

  sr_flop_driver #(.NCH(NCH), .TIMEOUT(TIMEOUT), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_val(req_val), .s(s), .r(r), .q(q), .qbar(qbar),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_chan(rsp_chan),
    .init_done(init_done), .init_err(init_err)
  );

  always #1 clk = ~clk;

  // Flop bank: sync reset via r has priority over s.
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (r[i])      fq[i] <= 1'b0;
      else if (s[i]) fq[i] <= 1'b1;
    end
  end
  assign q    = fq & ~stuck0;
  assign qbar = ~fq;

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      n_checks++;
      if (((s & r) != '0) || !($onehot0(s | r) || ((r == '1) && (s == '0)))) begin
        n_fail++;
        $display("FAIL sr_invariant: s=%b r=%b, required disjoint and at most one bit", s, r);
      end
    end
  end

  task automatic release_and_check_init(input string nm);
    int r_cycles = 0;
    int done_at = 0;
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (r == '1) r_cycles++;
      if (init_done && (done_at == 0)) done_at = k;
    end
    n_checks++;
    if (r_cycles != 1) begin n_fail++; $display("FAIL %s_r_pulse: r=1111 for %0d cycles, required 1", nm, r_cycles); end
    n_checks++;
    if (done_at < 1 || done_at > 3) begin n_fail++; $display("FAIL %s_done: init_done at cycle %0d, required 1..3", nm, done_at); end
    n_checks++;
    if (q !== 4'b0000 || qbar !== 4'b1111) begin n_fail++; $display("FAIL %s_bank: q=%b qbar=%b, required 0000 1111", nm, q, qbar); end
    n_checks++;
    if (init_err !== 1'b0) begin n_fail++; $display("FAIL %s_err: init_err=%b, required 0", nm, init_err); end
    m_known = '1; m_shadow = '0; m_flop = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s, r, req_ready, rsp_valid, rsp_err, rsp_chan, init_done, init_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: s=%b r=%b rdy=%b vld=%b err=%b chan=%0d done=%b ierr=%b, required all 0",
               s, r, req_ready, rsp_valid, rsp_err, rsp_chan, init_done, init_err);
    end
    mon_en = 1'b1;
    release_and_check_init("init");
  endtask

  task automatic do_req(input int c, input bit v, input string nm);
    logic [NCH-1:0] sel, exp_s, exp_r, seen_s, seen_r;
    int  exp_lat, lat, n, pulses, exp_pulses;
    bit  exp_err, got, rdy_busy, ok;
    sel = (c < NCH) ? (NCH'(1) << c) : '0;
    exp_s = '0; exp_r = '0; exp_pulses = 0;
    if (c >= NCH) begin
      exp_lat = 1; exp_err = 1'b1;
    end else if (m_known[c] && (m_shadow[c] == v)) begin
      exp_lat = 1; exp_err = 1'b0;
    end else begin
      exp_pulses = 1;
      if (v) exp_s = sel; else exp_r = sel;
      m_flop[c] = v;
      ok = ((m_flop[c] & ~stuck0[c]) == v) && (~m_flop[c] == !v);
      exp_lat = ok ? 3 : 2 + TIMEOUT;
      exp_err = !ok;
      m_known[c] = ok;
      if (ok) m_shadow[c] = v;
    end

    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: req_ready=%b after %0d cycles, required 1", nm, req_ready, n); end
    req_valid = 1'b1; req_chan = IDXW'(c); req_val = v;
    @(negedge clk);
    req_valid = 1'b0;

    lat = 1; got = 0; seen_s = '0; seen_r = '0; pulses = 0; rdy_busy = 0;
    while (lat <= 12) begin
      seen_s |= s; seen_r |= r;
      if ((s | r) != '0) pulses++;
      if (rsp_valid) begin got = 1; break; end
      if (req_ready) rdy_busy = 1;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL %s_rsp: no rsp_valid within 12 cycles, required at cycle %0d", nm, exp_lat); end
    n_checks++;
    if (got && lat != exp_lat) begin n_fail++; $display("FAIL %s_latency: rsp at cycle %0d, required %0d", nm, lat, exp_lat); end
    n_checks++;
    if (rsp_err !== exp_err || rsp_chan !== IDXW'(c)) begin
      n_fail++; $display("FAIL %s_rsp_fields: err=%b chan=%0d, required err=%b chan=%0d", nm, rsp_err, rsp_chan, exp_err, c);
    end
    n_checks++;
    if (seen_s !== exp_s || seen_r !== exp_r || pulses != exp_pulses) begin
      n_fail++; $display("FAIL %s_pulse: s=%b r=%b over %0d cycles, required s=%b r=%b over %0d", nm, seen_s, seen_r, pulses, exp_s, exp_r, exp_pulses);
    end
    n_checks++;
    if (rdy_busy) begin n_fail++; $display("FAIL %s_holdoff: req_ready=1 while busy, required 0", nm); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s_rsp_len: rsp_valid=%b after strobe, required 0", nm, rsp_valid); end
    n_checks++;
    if (q !== (m_flop & ~stuck0) || qbar !== ~m_flop) begin
      n_fail++; $display("FAIL %s_bank: q=%b qbar=%b, required %b %b", nm, q, qbar, m_flop & ~stuck0, ~m_flop);
    end
  endtask

  task automatic test_set();       do_req(2, 1'b1, "set_ch2");    endtask
  task automatic test_noop();      do_req(2, 1'b1, "noop_ch2");   endtask
  task automatic test_bad_index(); do_req(5, 1'b0, "bad_idx5");   endtask

  task automatic test_stuck();
    stuck0 = 4'b0010;
    do_req(1, 1'b1, "stuck_set_ch1");
    do_req(1, 1'b0, "stuck_clr_ch1");
    stuck0 = '0;
  endtask

  task automatic test_reset_mid_pulse();
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_chan = '0; req_val = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (s !== 4'b0001) begin n_fail++; $display("FAIL midrst_pulse: s=%b, required 0001", s); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s !== '0 || r !== '0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_values: s=%b r=%b vld=%b rdy=%b done=%b, required all 0", s, r, rsp_valid, req_ready, init_done);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_norsp: rsp_valid=%b, required 0", rsp_valid); end
    release_and_check_init("reinit");
  endtask

  task automatic test_soak();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), "soak");
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_noop();
    test_bad_index();
    test_stuck();
    test_reset_mid_pulse();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
